yolo_post_ctrl: RTL and testbench

Frame sequencer that sits between the upstream int8 AXI-stream source and the yolo_post detection datapath. It gates one 13x13x18-byte frame at a time into yolo_post and counts yolo_post's per-grid detect_valid pulses. On a clean frame it latches the 169-bit detection map and raises frame_done. On a malformed or aborted frame it zero-pads to the frame boundary, so yolo_post's free-running byte and grid counters stay aligned, and it reports error flags.

---
 rtl/yolo_post_pkg.sv | 27 ++
 rtl/yolo_post_ctrl_if.sv | 12 +
 rtl/yolo_post_ctrl.sv | 152 +++++++++++++++
 tb/tb_yolo_post_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_post_pkg.sv
// rtl/yolo_post_pkg.sv - shared constants, error bit indices and FSM states for the yolo_post frame sequencer
package yolo_post_pkg;

  localparam int NO_GRIDS    = 13;
  localparam int IMG_GRIDS   = 169;
  localparam int NO_BYTES    = 18;
  localparam int FRAME_BYTES = IMG_GRIDS * NO_BYTES;
  localparam int TIMEOUT_CYC = 64;

  localparam int BCNT_W = 12;
  localparam int GCNT_W = 8;
  localparam int TCNT_W = 7;

  localparam int ERR_EARLY_TLAST   = 0;
  localparam int ERR_MISSING_TLAST = 1;
  localparam int ERR_ABORT         = 2;
  localparam int ERR_TIMEOUT       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/yolo_post_ctrl_if.sv
// rtl/yolo_post_ctrl_if.sv - byte stream bundle between the upstream source, the sequencer and yolo_post
interface yolo_post_ctrl_if;

  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/yolo_post_ctrl.sv
// rtl/yolo_post_ctrl.sv - gates one frame at a time into yolo_post, pads short frames, latches the detection map
module yolo_post_ctrl
  import yolo_post_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  yolo_post_ctrl_if.slave      s_axis,
  yolo_post_ctrl_if.master     m_axis,
  input  logic                 detect_valid,
  input  logic [IMG_GRIDS-1:0] row_det_flat,
  output logic [IMG_GRIDS-1:0] det_map,
  output logic                 busy,
  output logic                 frame_done,
  output logic [3:0]           err_flags,
  output logic [15:0]          frame_cnt
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);
  localparam logic [BCNT_W-1:0] FULL_CNT  = BCNT_W'(FRAME_BYTES);
  localparam logic [GCNT_W-1:0] LAST_GRID = GCNT_W'(IMG_GRIDS - 1);
  localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(TIMEOUT_CYC);

  state_t               r_state;
  logic [BCNT_W-1:0]    r_byte_cnt;
  logic [GCNT_W-1:0]    r_grid_cnt;
  logic [TCNT_W-1:0]    r_tmo_cnt;
  logic [3:0]           r_err;
  logic [IMG_GRIDS-1:0] r_det_map;
  logic [15:0]          r_frame_cnt;
  logic                 r_frame_done;
  logic [3:0]           r_err_flags;

  state_t     w_state_nxt;
  logic [3:0] w_err_nxt;
  logic       w_clear;
  logic       w_xfer;
  logic       w_s_tready;
  logic       w_m_tvalid;
  logic [7:0] w_m_tdata;
  logic       w_last_byte;
  logic       w_grid_done;
  logic       w_grid_count_en;

  assign w_last_byte     = (r_byte_cnt == LAST_BYTE);
  assign w_grid_done     = detect_valid && (r_grid_cnt == LAST_GRID);
  assign w_grid_count_en = detect_valid &&
                           ((r_state == ST_STREAM) || (r_state == ST_FLUSH) || (r_state == ST_DRAIN));

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_clear     = 1'b0;
    w_xfer      = 1'b0;
    w_s_tready  = 1'b0;
    w_m_tvalid  = 1'b0;
    w_m_tdata   = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_STREAM;
          w_clear     = 1'b1;
          w_err_nxt   = 4'd0;
        end
      end
      ST_STREAM: begin
        w_m_tvalid = s_axis.tvalid;
        w_m_tdata  = s_axis.tdata;
        w_s_tready = m_axis.tready;
        w_xfer     = s_axis.tvalid && m_axis.tready;
        if (w_xfer && w_last_byte) begin
          // Full byte count reached: the frame is complete whatever tlast says.
          if (!s_axis.tlast) w_err_nxt[ERR_MISSING_TLAST] = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (w_xfer && s_axis.tlast) begin
          w_err_nxt[ERR_EARLY_TLAST] = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
        if (abort) begin
          w_err_nxt[ERR_ABORT] = 1'b1;
          if (w_state_nxt == ST_STREAM) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Zero padding keeps yolo_post's free-running byte/grid counters on the frame boundary.
        w_m_tvalid = (r_byte_cnt != FULL_CNT);
        w_xfer     = w_m_tvalid && m_axis.tready;
        if (!w_m_tvalid || (w_xfer && w_last_byte)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_grid_done) begin
          w_state_nxt = ST_DONE;
        end else if (r_tmo_cnt == TMO_LIMIT) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_cnt   <= '0;
      r_grid_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_err        <= '0;
      r_det_map    <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_err_flags  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_err        <= w_err_nxt;
      r_frame_done <= 1'b0;
      r_err_flags  <= '0;

      if (w_clear)     r_byte_cnt <= '0;
      else if (w_xfer) r_byte_cnt <= r_byte_cnt + 1'b1;

      if (w_clear)              r_grid_cnt <= '0;
      else if (w_grid_count_en) r_grid_cnt <= r_grid_cnt + 1'b1;

      if (r_state == ST_DRAIN) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                     r_tmo_cnt <= '0;

      if (w_state_nxt == ST_DONE) begin
        r_frame_done <= 1'b1;
        r_err_flags  <= w_err_nxt;
        if (w_err_nxt == 4'd0) begin
          r_det_map   <= row_det_flat;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign s_axis.tready = w_s_tready;
  assign m_axis.tvalid = w_m_tvalid;
  assign m_axis.tdata  = w_m_tdata;
  assign m_axis.tlast  = w_m_tvalid && w_last_byte;

  assign det_map    = r_det_map;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign err_flags  = r_err_flags;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_yolo_post_ctrl.sv
// tb/tb_yolo_post_ctrl.sv - frame-level bench for yolo_post_ctrl with a behavioural yolo_post stand-in
module tb_yolo_post_ctrl;
  import yolo_post_pkg::*;

  typedef struct {
    int         tlast_pos;
    int         abort_pos;
    int         tready_mode;
    int         hit_grid;
    bit         mute;
    logic [3:0] exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]   err;
    logic [168:0] map;
    logic [15:0]  fcnt;
    int           up;
    bit           clean;
    bit           tmo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         detect_valid;
  logic [168:0] row_det_flat;
  logic [168:0] det_map;
  logic         busy;
  logic         frame_done;
  logic [3:0]   err_flags;
  logic [15:0]  frame_cnt;

  yolo_post_ctrl_if s_axis ();
  yolo_post_ctrl_if m_axis ();

  yolo_post_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .detect_valid (detect_valid),
    .row_det_flat (row_det_flat),
    .det_map      (det_map),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_flags    (err_flags),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [168:0] act, input logic [168:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // yolo_post stand-in: a grid detects when its bytes 4 and 5 are both 127; pulse 2 cycles after its last byte
  bit         mute = 1'b0;
  logic [7:0] st_pos, st_grid, st_d1_grid;
  logic       st_b4, st_b5, st_d1, st_d1_hit;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pos <= '0; st_grid <= '0; st_d1_grid <= '0;
      st_b4 <= 1'b0; st_b5 <= 1'b0; st_d1 <= 1'b0; st_d1_hit <= 1'b0;
      detect_valid <= 1'b0; row_det_flat <= '0;
    end else begin
      st_d1 <= 1'b0;
      detect_valid <= st_d1 & ~mute;
      if (st_d1) row_det_flat[st_d1_grid] <= st_d1_hit;
      if (m_axis.tvalid && m_axis.tready) begin
        if (st_pos == 8'd4) st_b4 <= (m_axis.tdata == 8'd127);
        if (st_pos == 8'd5) st_b5 <= (m_axis.tdata == 8'd127);
        if (st_pos == 8'd17) begin
          st_pos     <= '0;
          st_d1      <= 1'b1;
          st_d1_hit  <= st_b4 & st_b5;
          st_d1_grid <= st_grid;
          st_grid    <= (st_grid == 8'd168) ? 8'd0 : st_grid + 8'd1;
        end else begin
          st_pos <= st_pos + 8'd1;
        end
      end
    end
  end

  // Scoreboard monitor: sampled 2 time units after the negedge, when the driver's inputs have settled
  exp_t sb[$];
  int   m_cnt = 0, up_cnt = 0, last_x = 0, done_seen = 0;
  bit   prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      m_cnt = 0; up_cnt = 0; prev_done = 1'b0;
    end else begin
      if (m_axis.tvalid && m_axis.tready) begin m_cnt++; last_x = cyc; end
      if (s_axis.tvalid && s_axis.tready) up_cnt++;
      if (prev_done) begin
        check("done_one_cycle", frame_done, 0);
        check("err_flags_one_cycle", err_flags, 0);
      end
      if (frame_done) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("err_flags", err_flags, e.err);
          check("det_map", det_map, e.map);
          check("frame_cnt", frame_cnt, e.fcnt);
          check("bytes_to_yolo_post", m_cnt, FRAME_BYTES);
          check("bytes_from_upstream", up_cnt, e.up);
          if (e.clean) check("clean_done_within_4", (cyc - last_x) <= 4, 1);
          if (e.tmo)   check("timeout_latency", cyc - last_x, TIMEOUT_CYC + 2);
        end
        m_cnt = 0; up_cnt = 0; done_seen++;
      end
      prev_done = frame_done;
    end
  end

  logic [168:0] mdl_map = '0;
  logic [15:0]  mdl_fcnt = '0;

  function automatic logic [7:0] byte_val(input int hit, input int i);
    int g, p;
    g = i / NO_BYTES;
    p = i % NO_BYTES;
    return (g == hit && (p == 4 || p == 5)) ? 8'd127 : 8'd0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    mdl_map = '0;
    mdl_fcnt = '0;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    int   i, stop_at, n, d0;
    bit   stop, hs;
    stop_at = FRAME_BYTES - 1;
    if (v.tlast_pos >= 0 && v.tlast_pos < stop_at) stop_at = v.tlast_pos;
    if (v.abort_pos >= 0 && v.abort_pos < stop_at) stop_at = v.abort_pos;
    if (v.exp_err == 4'd0) begin
      mdl_map = '0;
      mdl_map[v.hit_grid] = 1'b1;
      mdl_fcnt++;
    end
    e.err = v.exp_err; e.map = mdl_map; e.fcnt = mdl_fcnt; e.up = stop_at + 1;
    e.clean = (v.exp_err == 4'd0); e.tmo = v.exp_err[ERR_TIMEOUT];
    sb.push_back(e);
    mute = v.mute;
    d0 = done_seen;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    i = 0; stop = 1'b0; n = 0;
    while (!stop && n < 20000) begin
      m_axis.tready = (v.tready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = byte_val(v.hit_grid, i);
      s_axis.tlast  = (i == v.tlast_pos);
      abort         = (i == v.abort_pos);
      start         = (i == 500);
      #1;
      hs = s_axis.tready;
      if (abort || (hs && (s_axis.tlast || i == FRAME_BYTES - 1))) stop = 1'b1;
      if (hs) i++;
      @(negedge clk);
      n++;
    end
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = 8'd0;
    abort = 1'b0; start = 1'b0;
    n = 0;
    while (done_seen == d0 && n < 20000) begin
      m_axis.tready = (v.tready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      n++;
    end
    mute = 1'b0;
    if (done_seen == d0) begin
      check("frame_done_timeout", 0, 1);
      do_reset();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3041,   -1, 0,   0, 1'b0, 4'b0000};
    vecs[1] = '{3041,   -1, 1,   0, 1'b0, 4'b0000};
    vecs[2] = '{  99,   -1, 0,   5, 1'b0, 4'b0001};
    vecs[3] = '{3041,   -1, 0,  14, 1'b0, 4'b0000};
    vecs[4] = '{3041, 1000, 0,   0, 1'b0, 4'b0100};
    vecs[5] = '{  -1,   -1, 0,   2, 1'b0, 4'b0010};
    vecs[6] = '{3041,   -1, 0,   7, 1'b1, 4'b1000};
    vecs[7] = '{3041,   -1, 1, 168, 1'b0, 4'b0000};

    s_axis.tvalid = 1'b0; s_axis.tdata = 8'd0; s_axis.tlast = 1'b0;
    m_axis.tready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err_flags", err_flags, 0);
    check("reset_det_map", det_map, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_m_tvalid", m_axis.tvalid, 0);
    rst_n = 1'b1;

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_frame_done", frame_done, 0);

    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_axis.tvalid = 1'b1;
    m_axis.tready = 1'b1;
    repeat (200) @(negedge clk);
    check("busy_mid_stream", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_det_map", det_map, 0);
    check("async_rst_frame_cnt", frame_cnt, 0);
    check("async_rst_m_tvalid", m_axis.tvalid, 0);
    check("async_rst_s_tready", s_axis.tready, 0);
    check("async_rst_err_flags", err_flags, 0);
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
